// File: rtl/aes_key_scheduler.sv
// Iterative AES-128 key expansion into an 11-entry round-key store, streamed out in transposed byte layout.
// Optional reverse (decrypt) stream order is enabled by defining AES_KEY_SCHED_DECRYPT_EN, which adds the dir port.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

  // Multiplicative inverse as a^254 (maps 0 to 0), then the AES affine transform.
  always_comb begin
    x2   = gmul(a_i, a_i);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    s_o  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_scheduler #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:127] key,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         stream_start,
`ifdef AES_KEY_SCHED_DECRYPT_EN
  input  logic         dir,
`endif
  output logic [0:127] round_key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  output logic         keys_loaded
);
  typedef enum logic [1:0] {IDLE, EXPAND, LOADED, STREAM} state_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_t       state_q, state_d;
  logic [0:127] rk_q [0:NR];
  logic [0:127] prev_q;
  logic [3:0]   rnd_q, ptr_q;
  logic [7:0]   rcon_q;
  logic         dir_q, keys_loaded_q;

  logic         key_fire, start_fire, at_last, start_dir;
  logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7, rot_w, sub_w;
  logic [0:127] next_key, rk_cur, rk_t;

`ifdef AES_KEY_SCHED_DECRYPT_EN
  assign start_dir = dir;
`else
  assign start_dir = 1'b0;
`endif

  assign key_ready  = !reset && (state_q == IDLE || state_q == LOADED);
  assign key_fire   = key_valid && key_ready;
  assign start_fire = (state_q == LOADED) && stream_start && !key_fire;
  assign at_last    = dir_q ? (ptr_q == 4'd0) : (ptr_q == LAST_RND);

  // One expansion step from the most recently written round key.
  assign w0    = prev_q[0:31];
  assign w1    = prev_q[32:63];
  assign w2    = prev_q[64:95];
  assign w3    = prev_q[96:127];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (.a_i(rot_w[8*gi +: 8]), .s_o(sub_w[8*gi +: 8]));
  end

  assign w4       = w0 ^ sub_w ^ {rcon_q, 24'h0};
  assign w5       = w1 ^ w4;
  assign w6       = w2 ^ w5;
  assign w7       = w3 ^ w6;
  assign next_key = {w4, w5, w6, w7};

  assign rk_cur = rk_q[ptr_q];
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    for (genvar gj = 0; gj < 4; gj++) begin : g_col
      assign rk_t[8*(4*gi+gj) +: 8] = rk_cur[8*(4*gj+gi) +: 8];
    end
  end

  assign rk_valid    = (state_q == STREAM);
  assign rk_last     = rk_valid && at_last;
  assign round_key   = rk_valid ? rk_t : '0;
  assign keys_loaded = keys_loaded_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_fire) state_d = EXPAND;
      EXPAND:  if (rnd_q == LAST_RND) state_d = LOADED;
      LOADED:  if (key_fire) state_d = EXPAND;
               else if (stream_start) state_d = STREAM;
      STREAM:  if (rk_ready && at_last) state_d = LOADED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
      prev_q        <= '0;
      rnd_q         <= '0;
      rcon_q        <= '0;
      ptr_q         <= '0;
      dir_q         <= 1'b0;
      keys_loaded_q <= 1'b0;
    end else begin
      if (key_fire) begin
        rk_q[0]       <= key;
        prev_q        <= key;
        rnd_q         <= 4'd1;
        rcon_q        <= 8'h01;
        keys_loaded_q <= 1'b0;
      end else if (state_q == EXPAND) begin
        rk_q[rnd_q] <= next_key;
        prev_q      <= next_key;
        rnd_q       <= rnd_q + 4'd1;
        rcon_q      <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (rnd_q == LAST_RND) keys_loaded_q <= 1'b1;
      end
      if (start_fire) begin
        ptr_q <= start_dir ? LAST_RND : 4'd0;
        dir_q <= start_dir;
      end else if (state_q == STREAM && rk_ready && !at_last) begin
        ptr_q <= dir_q ? ptr_q - 4'd1 : ptr_q + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_aes_key_scheduler.sv
// Directed bench for aes_key_scheduler using the FIPS-197 and all-zero key expansions.
// Define AES_KEY_SCHED_DECRYPT_EN for both bench and design to exercise reverse streaming.

module tb_aes_key_scheduler;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [0:127] key = '0;
  logic         key_valid = 1'b0;
  logic         stream_start = 1'b0;
  logic         rk_ready = 1'b0;
`ifdef AES_KEY_SCHED_DECRYPT_EN
  logic         dir = 1'b0;
`endif
  logic         key_ready, rk_valid, rk_last, keys_loaded;
  logic [0:127] round_key;

  int checks = 0;
  int errors = 0;

  logic [0:127] fips_rk [0:10];
  logic [0:127] zero_rk [0:2];
  logic [0:127] fips_key;
  logic [0:127] first_beat;

  always #5 clk = ~clk;

  aes_key_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .key          (key),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .stream_start (stream_start),
`ifdef AES_KEY_SCHED_DECRYPT_EN
    .dir          (dir),
`endif
    .round_key    (round_key),
    .rk_valid     (rk_valid),
    .rk_ready     (rk_ready),
    .rk_last      (rk_last),
    .keys_loaded  (keys_loaded)
  );

  function automatic logic [0:127] tr(input logic [0:127] v);
    logic [0:127] r;
    r = '0;
    for (int l = 0; l < 4; l++)
      for (int m = 0; m < 4; m++)
        r[8*(4*l+m) +: 8] = v[8*(4*m+l) +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_key_ready got=%b want=0", key_ready); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid got=%b want=0", rk_valid); end
    checks++; if (rk_last !== 1'b0) begin errors++; $display("FAIL reset_rk_last got=%b want=0", rk_last); end
    checks++; if (keys_loaded !== 1'b0) begin errors++; $display("FAIL reset_keys_loaded got=%b want=0", keys_loaded); end
    checks++; if (round_key !== 128'h0) begin errors++; $display("FAIL reset_round_key got=%h want=0", round_key); end
    reset = 1'b0;
    step();
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL idle_key_ready got=%b want=1", key_ready); end
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL idle_start_ignored rk_valid got=%b want=0", rk_valid); end
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_expand(input logic [0:127] k);
    key = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL expand_start_key_ready got=%b want=0", key_ready); end
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (keys_loaded !== (i == 10)) begin
        errors++; $display("FAIL expand_keys_loaded cycle=%0d got=%b want=%b", i, keys_loaded, (i == 10));
      end
      checks++;
      if (key_ready !== (i == 10)) begin
        errors++; $display("FAIL expand_key_ready cycle=%0d got=%b want=%b", i, key_ready, (i == 10));
      end
    end
    $display("expand: key %h loaded after 10 cycles", k);
  endtask

  task automatic test_stream(input bit rev);
    int idx;
    rk_ready = 1'b1;
`ifdef AES_KEY_SCHED_DECRYPT_EN
    dir = rev;
`endif
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    for (int b = 0; b <= 10; b++) begin
      idx = rev ? 10 - b : b;
      checks++; if (rk_valid !== 1'b1) begin errors++; $display("FAIL stream_rk_valid beat=%0d got=%b want=1", b, rk_valid); end
      checks++; if (round_key !== tr(fips_rk[idx])) begin errors++; $display("FAIL stream_round_key beat=%0d got=%h want=%h", b, round_key, tr(fips_rk[idx])); end
      checks++; if (rk_last !== (b == 10)) begin errors++; $display("FAIL stream_rk_last beat=%0d got=%b want=%b", b, rk_last, (b == 10)); end
      checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL stream_key_ready beat=%0d got=%b want=0", b, key_ready); end
      if ((rev && b == 10) || (!rev && b == 0)) begin
        checks++; if (round_key !== first_beat) begin errors++; $display("FAIL stream_key0_literal beat=%0d got=%h want=%h", b, round_key, first_beat); end
      end
      $display("stream rev=%0b beat %0d round_key=%h last=%b", rev, b, round_key, rk_last);
      step();
    end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL stream_end_rk_valid got=%b want=0", rk_valid); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL stream_end_key_ready got=%b want=1", key_ready); end
`ifdef AES_KEY_SCHED_DECRYPT_EN
    dir = 1'b0;
`endif
  endtask

  task automatic test_backpressure();
    int idx;
    int cyc;
    bit stalled;
    logic [0:127] held;
    logic held_last;
    idx = 0; cyc = 0; stalled = 1'b0; held = '0; held_last = 1'b0;
    rk_ready = 1'b0;
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    while (idx < 11 && cyc < 300) begin
      rk_ready = 1'($urandom_range(0, 1));
      checks++; if (rk_valid !== 1'b1) begin errors++; $display("FAIL bp_rk_valid cyc=%0d got=%b want=1", cyc, rk_valid); end
      if (stalled) begin
        checks++; if (round_key !== held) begin errors++; $display("FAIL bp_stall_stable cyc=%0d got=%h want=%h", cyc, round_key, held); end
        checks++; if (rk_last !== held_last) begin errors++; $display("FAIL bp_stall_last cyc=%0d got=%b want=%b", cyc, rk_last, held_last); end
      end
      if (rk_ready) begin
        checks++; if (round_key !== tr(fips_rk[idx])) begin errors++; $display("FAIL bp_round_key beat=%0d got=%h want=%h", idx, round_key, tr(fips_rk[idx])); end
        checks++; if (rk_last !== (idx == 10)) begin errors++; $display("FAIL bp_rk_last beat=%0d got=%b want=%b", idx, rk_last, (idx == 10)); end
        $display("backpressure beat %0d round_key=%h at cycle %0d", idx, round_key, cyc);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = round_key;
        held_last = rk_last;
      end
      step();
      cyc++;
    end
    checks++; if (idx != 11) begin errors++; $display("FAIL bp_timeout beats got=%0d want=11", idx); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL bp_end_rk_valid got=%b want=0", rk_valid); end
    rk_ready = 1'b1;
  endtask

  task automatic test_key_wins();
    int cyc;
    key = '0;
    key_valid = 1'b1;
    stream_start = 1'b1;
    step();
    key_valid = 1'b0;
    stream_start = 1'b0;
    checks++; if (keys_loaded !== 1'b0) begin errors++; $display("FAIL keywins_keys_loaded got=%b want=0", keys_loaded); end
    for (int i = 1; i <= 10; i++) begin
      checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL keywins_no_stream cycle=%0d got=%b want=0", i, rk_valid); end
      step();
    end
    checks++; if (keys_loaded !== 1'b1) begin errors++; $display("FAIL keywins_loaded got=%b want=1", keys_loaded); end
    rk_ready = 1'b1;
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    key = fips_key;
    for (int b = 0; b <= 10; b++) begin
      if (b < 3) begin
        checks++; if (round_key !== tr(zero_rk[b])) begin errors++; $display("FAIL keywins_zero_key beat=%0d got=%h want=%h", b, round_key, tr(zero_rk[b])); end
      end
      checks++; if (rk_valid !== 1'b1) begin errors++; $display("FAIL keywins_rk_valid beat=%0d got=%b want=1", b, rk_valid); end
      $display("zero-key stream beat %0d round_key=%h", b, round_key);
      key_valid = (b >= 1 && b <= 5);
      step();
    end
    key_valid = 1'b0;
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL keywins_end_rk_valid got=%b want=0", rk_valid); end
    checks++; if (keys_loaded !== 1'b1) begin errors++; $display("FAIL keywins_stream_key_ignored got=%b want=1", keys_loaded); end
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    step();
    step();
    checks++; if (round_key !== tr(zero_rk[2])) begin errors++; $display("FAIL keywins_restream got=%h want=%h", round_key, tr(zero_rk[2])); end
    cyc = 0;
    while (rk_valid === 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL keywins_drain_timeout rk_valid got=%b want=0", rk_valid); end
  endtask

  task automatic test_reset_mid();
    key = fips_key;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    #1;
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL midexp_key_ready got=%b want=0", key_ready); end
    checks++; if (keys_loaded !== 1'b0) begin errors++; $display("FAIL midexp_keys_loaded got=%b want=0", keys_loaded); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL midexp_rk_valid got=%b want=0", rk_valid); end
    step();
    reset = 1'b0;
    step();
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL midexp_no_stream got=%b want=0", rk_valid); end
    checks++; if (keys_loaded !== 1'b0) begin errors++; $display("FAIL midexp_not_loaded got=%b want=0", keys_loaded); end
    test_expand(fips_key);
    test_stream(1'b0);

    rk_ready = 1'b1;
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (round_key !== tr(fips_rk[4])) begin errors++; $display("FAIL midstream_beat4 got=%h want=%h", round_key, tr(fips_rk[4])); end
    reset = 1'b1;
    #1;
    checks++; if (round_key !== 128'h0) begin errors++; $display("FAIL midstream_round_key got=%h want=0", round_key); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL midstream_rk_valid got=%b want=0", rk_valid); end
    checks++; if (rk_last !== 1'b0) begin errors++; $display("FAIL midstream_rk_last got=%b want=0", rk_last); end
    checks++; if (keys_loaded !== 1'b0) begin errors++; $display("FAIL midstream_keys_loaded got=%b want=0", keys_loaded); end
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL midstream_key_ready got=%b want=0", key_ready); end
    step();
    reset = 1'b0;
    step();
    test_expand(fips_key);
    test_stream(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fips_key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    first_beat  = 128'h2b28ab097eaef7cf15d2154f16a6883c;
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_rk[0]  = 128'h00000000000000000000000000000000;
    zero_rk[1]  = 128'h62636363626363636263636362636363;
    zero_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

    test_reset();
    test_expand(fips_key);
    test_stream(1'b0);
    test_backpressure();
    test_backpressure();
`ifdef AES_KEY_SCHED_DECRYPT_EN
    test_stream(1'b1);
    test_stream(1'b0);
`endif
    test_key_wins();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
